// File: rtl/data_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : data_mem_ctrl                                                    |
// | Purpose  : Load/store data memory controller. Accepts one request at a     |
// |            time on a valid/ready handshake, performs the byte/half/word     |
// |            array access one cycle later, and then holds the response        |
// |            until the consumer accepts it.                                   |
// | Ports    : clk, rst              - clock, synchronous active-high reset      |
// |            req_valid/req_ready   - request handshake (ready only in IDLE)    |
// |            req_we, req_size,     - store flag, access size, zero-extend flag |
// |            req_unsigned                                                     |
// |            req_addr, req_wdata   - byte address, right-aligned store data    |
// |            req_rd                - tag echoed back on rsp_rd                 |
// |            rsp_valid/rsp_ready   - response handshake                        |
// |            rsp_rdata, rsp_rd,    - extended load data, tag, store echo,      |
// |            rsp_we, rsp_err         error flag                                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module data_mem_ctrl #(
   parameter int DEPTH = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic [4:0]  rsp_rd,
   output logic        rsp_we,
   output logic        rsp_err
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   state_t        state_q;

   // Captured request
   logic          we_q;
   logic [1:0]    size_q;
   logic          uns_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic [4:0]    rd_q;

   // Registered response
   logic          rsp_valid_q;
   logic [31:0]   rsp_rdata_q;
   logic [4:0]    rsp_rd_q;
   logic          rsp_we_q;
   logic          rsp_err_q;

   logic [31:0]   mem_q [DEPTH];

   // Access-cycle datapath, all derived from the captured request
   logic [AW-1:0] word_idx;
   logic [31:0]   rd_word;
   logic [31:0]   shifted;
   logic [31:0]   lane_mask;
   logic [31:0]   lane_wdata;
   logic          err_d;
   logic [31:0]   rsp_rdata_d;
   logic [31:0]   mem_word_d;

   assign word_idx = addr_q[AW+1:2];

   always_comb begin
      rd_word     = mem_q[word_idx];
      // Bring the addressed lane down to bit 0 so extension is lane-independent
      shifted     = rd_word >> {addr_q[1:0], 3'b000};
      // Any set bit above the array index means the word is out of range
      err_d       = |addr_q[31:AW+2];
      lane_mask   = '0;
      lane_wdata  = wdata_q;
      rsp_rdata_d = '0;
      case (size_q)
         SZ_BYTE: begin
            lane_mask   = 32'h0000_00FF << {addr_q[1:0], 3'b000};
            lane_wdata  = {4{wdata_q[7:0]}};
            rsp_rdata_d = uns_q ? {24'd0, shifted[7:0]}
                                : {{24{shifted[7]}}, shifted[7:0]};
         end
         SZ_HALF: begin
            if (addr_q[0]) begin
               err_d = 1'b1;
            end
            lane_mask   = addr_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            lane_wdata  = {2{wdata_q[15:0]}};
            rsp_rdata_d = uns_q ? {16'd0, shifted[15:0]}
                                : {{16{shifted[15]}}, shifted[15:0]};
         end
         SZ_WORD: begin
            if (|addr_q[1:0]) begin
               err_d = 1'b1;
            end
            lane_mask   = 32'hFFFF_FFFF;
            rsp_rdata_d = rd_word;
         end
         default: begin
            err_d = 1'b1;
         end
      endcase
      // Stores and faulting requests always return zero data
      if (err_d || we_q) begin
         rsp_rdata_d = '0;
      end
      // Read-modify-write merge keeps the unselected lanes intact
      mem_word_d = (rd_word & ~lane_mask) | (lane_wdata & lane_mask);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         we_q        <= 1'b0;
         size_q      <= 2'b00;
         uns_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rd_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_rd_q    <= '0;
         rsp_we_q    <= 1'b0;
         rsp_err_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  size_q  <= req_size;
                  uns_q   <= req_unsigned;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  rd_q    <= req_rd;
                  state_q <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (we_q && !err_d) begin
                  mem_q[word_idx] <= mem_word_d;
               end
               rsp_valid_q <= 1'b1;
               rsp_rdata_q <= rsp_rdata_d;
               rsp_rd_q    <= rd_q;
               rsp_we_q    <= we_q;
               rsp_err_q   <= err_d;
               state_q     <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_rd    = rsp_rd_q;
   assign rsp_we    = rsp_we_q;
   assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire
